serial_matrix_mac: RTL

Sequential, parametrised NxN unsigned matrix multiplier: Result = A x B. It uses one multiplier and one accumulator and performs one multiply-accumulate per clock. Operands and result are row-major packed buses. A start/busy/done handshake lets the block sit behind a controller or register interface. Each result element is reduced to OW bits, either by wrap (modulo 2^OW) or by saturation, selected per operation.

---
 rtl/serial_matrix_mac.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/serial_matrix_mac.sv
// Sequential NxN unsigned matrix multiplier, Result = A x B.
// One multiply-accumulate per clock; each element is reduced to OW bits by wrap or saturation.
module serial_matrix_mac #(
   parameter int unsigned N  = 3,
   parameter int unsigned W  = 6,
   parameter int unsigned OW = 6
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                sat_mode,
   input  logic [N*N*W-1:0]    a_in,
   input  logic [N*N*W-1:0]    b_in,
   output logic                busy,
   output logic                done,
   output logic [N*N*OW-1:0]   result
);

   localparam int unsigned NE = N * N;
   localparam int unsigned IW = $clog2(N);
   localparam int unsigned EW = $clog2(NE);
   localparam int unsigned AW = 2 * W + $clog2(N);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e          state;
   logic [NE*W-1:0] a_q;
   logic [NE*W-1:0] b_q;
   logic            sat_q;
   logic [AW-1:0]   acc_q;
   logic [IW-1:0]   i_q;
   logic [IW-1:0]   j_q;
   logic [IW-1:0]   k_q;
   logic [OW-1:0]   work_q [NE];

   logic [W-1:0]    a_arr [NE];
   logic [W-1:0]    b_arr [NE];
   logic [OW-1:0]   work_d [NE];
   logic [EW-1:0]   a_idx;
   logic [EW-1:0]   b_idx;
   logic [EW-1:0]   w_idx;
   logic [2*W-1:0]  prod;
   logic [AW-1:0]   acc_next;
   logic [OW-1:0]   red;
   logic            last_k;
   logic            last_j;
   logic            last_elem;

   // Datapath: select operands, multiply-accumulate, reduce and merge into the working buffer.
   always_comb begin
      for (int e = 0; e < NE; e++) begin
         a_arr[e] = a_q[(NE-1-e)*W +: W];
         b_arr[e] = b_q[(NE-1-e)*W +: W];
      end
      a_idx    = EW'(i_q) * EW'(N) + EW'(k_q);
      b_idx    = EW'(k_q) * EW'(N) + EW'(j_q);
      w_idx    = EW'(i_q) * EW'(N) + EW'(j_q);
      prod     = a_arr[a_idx] * b_arr[b_idx];
      acc_next = acc_q + AW'(prod);
      // Any bit above OW set means the sum exceeds 2^OW-1; with OW == AW nothing can be above.
      if (sat_q && (|(acc_next >> OW))) begin
         red = '1;
      end else begin
         red = acc_next[OW-1:0];
      end
      work_d        = work_q;
      work_d[w_idx] = red;
      last_k        = (k_q == IW'(N-1));
      last_j        = (j_q == IW'(N-1));
      last_elem     = last_k && last_j && (i_q == IW'(N-1));
   end

   // Control FSM with registered busy/done/result; operands are frozen at acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= StIdle;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         a_q    <= '0;
         b_q    <= '0;
         sat_q  <= 1'b0;
         acc_q  <= '0;
         i_q    <= '0;
         j_q    <= '0;
         k_q    <= '0;
         work_q <= '{default: '0};
      end else begin
         case (state)
            StIdle: begin
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  a_q   <= a_in;
                  b_q   <= b_in;
                  sat_q <= sat_mode;
                  acc_q <= '0;
                  i_q   <= '0;
                  j_q   <= '0;
                  k_q   <= '0;
                  busy  <= 1'b1;
                  state <= StRun;
               end
            end
            StRun: begin
               if (!last_k) begin
                  acc_q <= acc_next;
                  k_q   <= k_q + 1'b1;
               end else begin
                  work_q <= work_d;
                  acc_q  <= '0;
                  k_q    <= '0;
                  if (last_j) begin
                     j_q <= '0;
                     i_q <= last_elem ? '0 : i_q + 1'b1;
                  end else begin
                     j_q <= j_q + 1'b1;
                  end
                  // Final element is forwarded straight into result on this edge.
                  if (last_elem) begin
                     for (int e = 0; e < NE; e++) begin
                        result[(NE-1-e)*OW +: OW] <= work_d[e];
                     end
                     done  <= 1'b1;
                     state <= StDone;
                  end
               end
            end
            StDone: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
